// File: rtl/split_slave_ctrl.sv
// Split-capable slave bus controller: single-word writes to local memory,
// long-latency reads released via split. Split mode enabled by SPLIT_SLAVE_SPLIT_EN.
//
// state      | meaning
// IDLE       | ready, sampling mvalid
// WACK       | write acknowledge pulse
// SPLIT      | read latency countdown (bus released when split enabled)
// WAIT_GRANT | split read done, waiting for split_grant
// RESP       | read data valid pulse
module split_slave_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int SPLIT_LAT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mvalid,
  input  logic              mwrite,
  input  logic [ADDR_W-1:0] maddr,
  input  logic [DATA_W-1:0] mwdata,
  input  logic              split_grant,
  output logic              sready,
  output logic              ssplit,
  output logic              srvalid,
  output logic [DATA_W-1:0] srdata,
  output logic              sack
);

  localparam int CNT_W = $clog2(SPLIT_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPLIT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WACK,
    SPLIT,
`ifdef SPLIT_SLAVE_SPLIT_EN
    WAIT_GRANT,
`endif
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] srdata_q;

  wire cnt_done = (state == SPLIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (mvalid) state_nxt = mwrite ? WACK : SPLIT;
      WACK:       state_nxt = IDLE;
`ifdef SPLIT_SLAVE_SPLIT_EN
      SPLIT:      if (cnt_done) state_nxt = WAIT_GRANT;
      WAIT_GRANT: if (split_grant) state_nxt = RESP;
`else
      SPLIT:      if (cnt_done) state_nxt = RESP;
`endif
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sready  = (state == IDLE);
    sack    = (state == WACK);
    srvalid = (state == RESP);
`ifdef SPLIT_SLAVE_SPLIT_EN
    ssplit  = (state == SPLIT);
`else
    ssplit  = 1'b0;
`endif
  end

  assign srdata = srdata_q;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && mvalid && mwrite) mem[maddr] <= mwdata;
  end

`ifdef SPLIT_SLAVE_SPLIT_EN
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      srdata_q <= '0;
    end else begin
      if (cnt_done) hold <= mem[addr_q];
      if (state == WAIT_GRANT && split_grant) srdata_q <= hold;
    end
  end
`else
  logic unused_split_grant;
  assign unused_split_grant = split_grant;

  // Without split the word goes straight to srdata on RESP entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           srdata_q <= '0;
    else if (cnt_done) srdata_q <= mem[addr_q];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt    <= '0;
    end else if (state == IDLE && mvalid && !mwrite) begin
      addr_q <= maddr;
      cnt    <= CNT_LOAD;
    end else if (state == SPLIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_split_slave_ctrl.sv
// Scoreboard bench for split_slave_ctrl; covers split and non-split builds.
module tb_split_slave_ctrl;

`ifdef SPLIT_SLAVE_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mvalid = 1'b0, mwrite = 1'b0, split_grant = 1'b0;
  logic [7:0] maddr = 8'h00, mwdata = 8'h00;
  logic       sready, ssplit, srvalid, sack;
  logic [7:0] srdata;

  split_slave_ctrl #(.ADDR_W(8), .DATA_W(8), .SPLIT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .mvalid(mvalid), .mwrite(mwrite), .maddr(maddr),
    .mwdata(mwdata), .split_grant(split_grant), .sready(sready), .ssplit(ssplit),
    .srvalid(srvalid), .srdata(srdata), .sack(sack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic rd; logic [7:0] data; } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (srvalid || sack)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp actual srvalid=%0b sack=%0b required=no_response", srvalid, sack);
      end else begin
        e = q.pop_front();
        if (e.rd) begin
          if (!(srvalid && !sack && srdata == e.data)) begin
            failures++;
            $display("FAIL read_resp actual srvalid=%0b sack=%0b srdata=%0h required srvalid=1 srdata=%0h",
                     srvalid, sack, srdata, e.data);
          end
        end else if (!(sack && !srvalid)) begin
          failures++;
          $display("FAIL write_resp actual sack=%0b srvalid=%0b required sack=1", sack, srvalid);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    q.push_back('{rd: 1'b0, data: 8'h00});
    mvalid = 1'b1; mwrite = 1'b1; maddr = a; mwdata = d;
    tick;
    mvalid = 1'b0; mwrite = 1'b0;
    chk("wr_sack", sack, 1);
    chk("wr_sready_low", sready, 0);
    tick;
    chk("wr_sready_back", sready, 1);
  endtask

  task automatic start_read(input logic [7:0] a, input logic [7:0] d);
    q.push_back('{rd: 1'b1, data: d});
    mvalid = 1'b1; mwrite = 1'b0; maddr = a;
    tick;
    mvalid = 1'b0;
  endtask

  task automatic wait_split_low;
    int g = 0;
    while (ssplit && g < 40) begin tick; g++; end
    chk("ssplit_fall_bound", (g < 40), 1);
  endtask

  task automatic wait_srvalid(output int k);
    k = 0;
    while (!srvalid && k < 60) begin tick; k++; end
  endtask

  task automatic pulse_grant;
    split_grant = 1'b1;
    tick;
    split_grant = 1'b0;
  endtask

  initial begin
    int n, k, nv, bad, seen;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready", sready, 1);
    chk("rst_ssplit", ssplit, 0);
    chk("rst_srvalid", srvalid, 0);
    chk("rst_sack", sack, 0);
    chk("rst_srdata", srdata, 8'h00);
    rst = 1'b0;
    tick;
    chk("post_rst_sready", sready, 1);

    // Write then read 0x3C
    do_write(8'h3C, 8'hA5);
    start_read(8'h3C, 8'hA5);
    chk("rd_sready_low", sready, 0);
    if (SPLIT_EN) begin
      n = 0;
      while (ssplit && n < 40) begin n++; tick; end
      chk("ssplit_len", n, LAT);
      chk("wait_sready_low", sready, 0);
      tick;
      chk("wait_no_srvalid", srvalid, 0);
      pulse_grant;
      chk("grant_srvalid", srvalid, 1);
      chk("grant_srdata", srdata, 8'hA5);
    end else begin
      k = 0; seen = 0;
      while (!srvalid && k < 60) begin
        if (ssplit) seen = 1;
        tick; k++;
      end
      chk("nosplit_ssplit_never", seen, 0);
      chk("nosplit_latency", k + 1, LAT + 1);
      chk("nosplit_srdata", srdata, 8'hA5);
    end
    tick;
    chk("rd_done_sready", sready, 1);
    chk("rd_done_srvalid", srvalid, 0);

    // Grant delay
    if (SPLIT_EN) begin
      do_write(8'h10, 8'h5A);
      start_read(8'h10, 8'h5A);
      wait_split_low;
      bad = 0;
      repeat (50) begin
        if (ssplit || srvalid || sready) bad++;
        tick;
      end
      chk("grant_hold", bad, 0);
      pulse_grant;
      nv = 0;
      repeat (10) begin if (srvalid) nv++; tick; end
      chk("grant_single_srvalid", nv, 1);
      chk("grant_srdata_5a", srdata, 8'h5A);
    end

    // Spurious inputs
    do_write(8'h00, 8'h11);
    do_write(8'h20, 8'h99);
    pulse_grant;
    chk("spur_idle_sready", sready, 1);
    chk("spur_idle_srvalid", srvalid, 0);
    start_read(8'h20, 8'h99);
    tick;
    split_grant = 1'b1; mvalid = 1'b1; mwrite = 1'b0; maddr = 8'h00;
    tick;
    split_grant = 1'b0; mvalid = 1'b0;
    chk("spur_split_ssplit", ssplit, SPLIT_EN);
    chk("spur_split_sready", sready, 0);
    if (SPLIT_EN) begin
      wait_split_low;
      tick;
      chk("spur_wait_srvalid", srvalid, 0);
      pulse_grant;
    end else begin
      wait_srvalid(k);
    end
    chk("spur_srvalid", srvalid, 1);
    chk("spur_srdata", srdata, 8'h99);
    nv = 0;
    tick;
    repeat (10) begin if (srvalid) nv++; tick; end
    chk("spur_no_extra", nv, 0);

    // Reset mid-split
    start_read(8'h3C, 8'hA5);
    repeat (3) tick;
    chk("mid_ssplit_before", ssplit, SPLIT_EN);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ssplit", ssplit, 0);
    chk("mid_rst_sready", sready, 1);
    chk("mid_rst_srdata", srdata, 8'h00);
    q.delete();
    tick;
    rst = 1'b0;
    tick;
    chk("mid_rst_idle", sready, 1);
    repeat (10) tick;
    pulse_grant;
    nv = 0;
    repeat (12) begin if (srvalid) nv++; tick; end
    chk("mid_rst_no_srvalid", nv, 0);
    chk("mid_rst_still_idle", sready, 1);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/split_slave_ctrl.md
# split_slave_ctrl

Bus-side controller for the split-capable slave (the `sreadysp` / `ssplit` / `split_grant` endpoint seen by the arbiter). It accepts single-word read/write transfers into a local memory. Long-latency reads release the bus via a split, then resume when the arbiter returns `split_grant`. Writes complete without a split.

## Interface
Parameters:
- ADDR_W, 8, address width; local memory holds 2^ADDR_W words.
- DATA_W, 8, data word width.
- SPLIT_LAT, 8, internal read latency in cycles (minimum 1).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- mvalid  in  1  master request valid; `mwrite`, `maddr` and `mwdata` are stable while it is high.
- mwrite  in  1  1 = write, 0 = read.
- maddr  in  ADDR_W  transfer address.
- mwdata  in  DATA_W  write data.
- split_grant  in  1  one-cycle pulse from the arbiter that permits the split read to finish.
- sready  out  1  slave ready; drives the arbiter's `sreadysp`.
- ssplit  out  1  split active; drives the arbiter's `ssplit`.
- srvalid  out  1  one-cycle read-data-valid pulse.
- srdata  out  DATA_W  read data; holds its last value.
- sack  out  1  one-cycle write-acknowledge pulse.

## Operation
- States: IDLE, WACK, SPLIT, WAIT_GRANT, RESP.
- IDLE:
  - `sready` = 1.
  - `mvalid` is sampled on every rising edge.
  - On a write, the memory is written at that edge and the next state is WACK.
  - On a read, address is captured and the next state is SPLIT.
- WACK:
  - `sack` = 1 and `sready` = 0 for exactly one cycle.
  - Next state is IDLE.
- SPLIT:
  - `ssplit` = 1 and `sready` = 0.
  - Down-counter loads SPLIT_LAT-1 on entry and decrements each cycle.
  - At count 0, the captured address's memory word is latched into a hold register.
  - Next state is WAIT_GRANT.
- WAIT_GRANT:
  - `ssplit` = 0 and `sready` = 0.
  - The arbiter sees `ssplit` fall and re-grants the split owner.
  - The state waits indefinitely for `split_grant`.
  - `split_grant` sampled high at an edge moves the state to RESP.
- RESP:
  - `srvalid` = 1 for one cycle, with `srdata` = hold register.
  - Next state is IDLE.
- Counter width is $clog2(SPLIT_LAT+1). The counter never wraps: it is reloaded only on SPLIT entry.
- `mvalid` outside IDLE is ignored; there is no queuing.
- `split_grant` outside WAIT_GRANT is ignored.
- `srdata` changes only on entry to RESP.
- Memory contents are not reset.
- Reset values: state IDLE, `sready` 1, `ssplit` 0, `srvalid` 0, `sack` 0, `srdata` 0, counter 0.
- Reset asserted mid-transfer (any state) discards the pending read immediately; outputs take their reset values asynchronously.

## Timing
- Write accepted at edge T: memory updated at T, `sack` high in cycle T..T+1, `sready` high again from edge T+1.
- Read accepted at edge T:
  - `ssplit` is high for exactly SPLIT_LAT cycles, from T to T+SPLIT_LAT.
  - `ssplit` is low from edge T+SPLIT_LAT.
- `split_grant` sampled at edge G (G ≥ T+SPLIT_LAT+1): `srvalid` high for cycle G..G+1, IDLE with `sready` = 1 from G+1.
- Minimum read turnaround is SPLIT_LAT+2 cycles, acceptance to `srvalid`.
- `split_grant` high at the very edge that enters WAIT_GRANT is not accepted; it is sampled only while in WAIT_GRANT.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration
- `SPLIT_SLAVE_SPLIT_EN`, defined: behaviour as above.
- Undefined:
  - `ssplit` is tied 0 and WAIT_GRANT is removed.
  - SPLIT becomes a wait state with `sready` = 0 and `ssplit` = 0.
  - At count 0 it goes directly to RESP; `split_grant` is ignored.
  - Read turnaround is exactly SPLIT_LAT+1 cycles.
  - The bus stays held by the requesting master for the full latency.

## Test plan
- Reset: assert `rst` for 3 cycles -> `sready` = 1, `ssplit` = 0, `srvalid` = 0, `sack` = 0, `srdata` = 0x00.
- Write then split read:
  - Stimulus: write 0xA5 to 0x3C; then read 0x3C; `split_grant` pulsed 2 cycles after `ssplit` falls.
  - Required: `sack` pulse 1 cycle after the write; `ssplit` high exactly 8 cycles; `srvalid` with `srdata` = 0xA5 one cycle after the grant edge.
- Grant delay: hold `split_grant` low 50 cycles in WAIT_GRANT -> `ssplit` stays 0, `srvalid` stays 0, `sready` stays 0; single grant pulse -> exactly one `srvalid`.
- Spurious inputs: pulse `split_grant` during IDLE and SPLIT, and assert `mvalid` (read 0x00) during SPLIT -> no state change, no extra `srvalid`, no captured address.
- Reset mid-split: assert `rst` at split cycle 4 -> `ssplit` falls asynchronously, IDLE after release; a later grant produces no `srvalid`.
- Macro undefined, SPLIT_LAT = 8: read 0x3C holding 0xA5 -> `ssplit` never asserts; `srvalid` with 0xA5 exactly 9 cycles after acceptance.
